// File: rtl/voice_allocator.sv
// Purpose: polyphonic voice allocator; maps note-on/off key events onto NUM_VOICES oscillator voices, stealing the oldest when all are busy.
// Latency: event accepted at edge E0, voice_key/voice_gate/steal_pulse update at edge E(NUM_VOICES+1).
// Backpressure: ev_ready is high only in IDLE; ev_valid while busy is ignored, so the source must hold the event.
//
// Ports:
//   clk, rst               clock and synchronous active-high reset
//   ev_valid/ev_ready      key event handshake; ev_on (1 = note-on) and ev_key are latched at accept
//   voice_key              key per voice, voice i at [i*KEY_W +: KEY_W]
//   voice_gate             1 = voice i sounding (held)
//   steal_pulse            one-cycle pulse when a held voice is reassigned
module voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int KEY_W      = 7,
  parameter int AGE_W      = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ev_valid,
  output logic                        ev_ready,
  input  logic                        ev_on,
  input  logic [KEY_W-1:0]            ev_key,
  output logic [NUM_VOICES*KEY_W-1:0] voice_key,
  output logic [NUM_VOICES-1:0]       voice_gate,
  output logic                        steal_pulse
);

  localparam int IDX_W = (NUM_VOICES > 2) ? $clog2(NUM_VOICES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    APPLY = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             lat_on;
  logic [KEY_W-1:0] lat_key;

  logic [KEY_W-1:0] keys [NUM_VOICES];
  logic [AGE_W-1:0] ages [NUM_VOICES];

  // Scan results, accumulated one voice per cycle.
  logic             match_vld;
  logic [IDX_W-1:0] match_idx;
  logic             free_vld;
  logic [IDX_W-1:0] free_idx;
  logic             old_vld;
  logic [IDX_W-1:0] old_idx;
  logic [AGE_W-1:0] old_age;

  logic [IDX_W-1:0] tgt_idx;

  assign ev_ready = (state == IDLE);

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_key_out
    assign voice_key[g*KEY_W +: KEY_W] = keys[g];
  end

  // Note-on target: retrigger a match, else take a free voice, else steal the oldest.
  always_comb begin
    tgt_idx = old_idx;
    if (match_vld)     tgt_idx = match_idx;
    else if (free_vld) tgt_idx = free_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      lat_on      <= 1'b0;
      lat_key     <= '0;
      voice_gate  <= '0;
      steal_pulse <= 1'b0;
      match_vld   <= 1'b0;
      match_idx   <= '0;
      free_vld    <= 1'b0;
      free_idx    <= '0;
      old_vld     <= 1'b0;
      old_idx     <= '0;
      old_age     <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        keys[i] <= '0;
        ages[i] <= '0;
      end
    end else begin
      steal_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (ev_valid) begin
            lat_on    <= ev_on;
            lat_key   <= ev_key;
            idx       <= '0;
            match_vld <= 1'b0;
            free_vld  <= 1'b0;
            old_vld   <= 1'b0;
            state     <= SCAN;
          end
        end

        SCAN: begin
          if (!match_vld && voice_gate[idx] && (keys[idx] == lat_key)) begin
            match_vld <= 1'b1;
            match_idx <= idx;
          end
          if (!free_vld && !voice_gate[idx]) begin
            free_vld <= 1'b1;
            free_idx <= idx;
          end
          // Strict compare on an ascending scan keeps ties on the lowest index.
          if (voice_gate[idx] && (!old_vld || (ages[idx] > old_age))) begin
            old_vld <= 1'b1;
            old_idx <= idx;
            old_age <= ages[idx];
          end
          idx <= idx + IDX_W'(1);
          if (idx == IDX_W'(NUM_VOICES - 1)) state <= APPLY;
        end

        APPLY: begin
          state <= IDLE;
          if (lat_on) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
              if (IDX_W'(i) == tgt_idx) begin
                ages[i] <= '0;
                if (!match_vld) begin
                  keys[i]       <= lat_key;
                  voice_gate[i] <= 1'b1;
                end
              end else if (voice_gate[i] && (ages[i] != {AGE_W{1'b1}})) begin
                ages[i] <= ages[i] + AGE_W'(1);
              end
            end
            steal_pulse <= !match_vld && !free_vld;
          end else if (match_vld) begin
            // Key is kept so the oscillator holds pitch through the release.
            voice_gate[match_idx] <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Purpose: self-checking bench for voice_allocator, directed scenarios plus random key events vs a behavioural model.
// Latency: checks outputs hold for 5 samples after accept and update at the 5th edge after accept.
// Backpressure: waits (bounded) for ev_ready before each event; pokes ev_valid while busy to confirm it is ignored.
module tb_voice_allocator;

  localparam int NV = 4;
  localparam int KW = 7;

  logic             clk = 1'b0;
  logic             rst;
  logic             ev_valid;
  logic             ev_ready;
  logic             ev_on;
  logic [KW-1:0]    ev_key;
  logic [NV*KW-1:0] voice_key;
  logic [NV-1:0]    voice_gate;
  logic             steal_pulse;

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model: plain arrays of key / gate / age per voice.
  int mkey  [NV];
  int mgate [NV];
  int mage  [NV];

  always #5 clk = ~clk;

  voice_allocator #(.NUM_VOICES(NV), .KEY_W(KW), .AGE_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_on      (ev_on),
    .ev_key     (ev_key),
    .voice_key  (voice_key),
    .voice_gate (voice_gate),
    .steal_pulse(steal_pulse)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NV*KW-1:0] exp_keys();
    logic [NV*KW-1:0] r;
    r = '0;
    for (int i = 0; i < NV; i++) r[i*KW +: KW] = KW'(mkey[i]);
    return r;
  endfunction

  function automatic logic [NV-1:0] exp_gates();
    logic [NV-1:0] r;
    r = '0;
    for (int i = 0; i < NV; i++) r[i] = (mgate[i] != 0);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      mkey[i]  = 0;
      mgate[i] = 0;
      mage[i]  = 0;
    end
  endtask

  // Applies one event to the model; returns 1 when a held voice gets stolen.
  function automatic bit model_event(input bit on, input int k);
    int m;
    int f;
    int o;
    int t;
    bit st;
    m = -1;
    f = -1;
    o = -1;
    for (int i = 0; i < NV; i++) begin
      if (m < 0 && mgate[i] != 0 && mkey[i] == k) m = i;
      if (f < 0 && mgate[i] == 0) f = i;
      if (mgate[i] != 0 && (o < 0 || mage[i] > mage[o])) o = i;
    end
    if (!on) begin
      if (m >= 0) mgate[m] = 0;
      return 1'b0;
    end
    t  = (m >= 0) ? m : ((f >= 0) ? f : o);
    st = (m < 0) && (f < 0);
    for (int i = 0; i < NV; i++)
      if (i != t && mgate[i] != 0) mage[i] = (mage[i] < 255) ? mage[i] + 1 : 255;
    mage[t] = 0;
    if (m < 0) begin
      mkey[t]  = k;
      mgate[t] = 1;
    end
    return st;
  endfunction

  task automatic check_all(input string tag, input bit exp_steal);
    check({tag, "_gate"},  voice_gate,  exp_gates());
    check({tag, "_keys"},  voice_key,   exp_keys());
    check({tag, "_steal"}, steal_pulse, exp_steal);
    check({tag, "_ready"}, ev_ready,    1'b1);
  endtask

  // Called #1 after a posedge. Returns #1 after the edge where outputs update.
  task automatic send(input bit on, input int k);
    int n;
    bit st;
    n = 0;
    while (!ev_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("accept_ready", ev_ready, 1'b1);
    ev_valid = 1'b1;
    ev_on    = on;
    ev_key   = KW'(k);
    @(posedge clk); #1;
    ev_valid = 1'b0;
    ev_on    = 1'($urandom);
    ev_key   = KW'($urandom);
    for (int c = 0; c < 5; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      check("busy_ready", ev_ready,    1'b0);
      check("busy_steal", steal_pulse, 1'b0);
      check("busy_keys",  voice_key,   exp_keys());
      check("busy_gate",  voice_gate,  exp_gates());
      ev_valid = (c < 4) ? 1'($urandom) : 1'b0;
    end
    ev_valid = 1'b0;
    @(posedge clk); #1;
    st = model_event(on, k);
    check_all("apply", st);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int pool [8];
    pool = '{0, 5, 25, 40, 52, 60, 79, 127};
    rst      = 1'b1;
    ev_valid = 1'b0;
    ev_on    = 1'b0;
    ev_key   = '0;
    model_reset();

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    check_all("reset", 1'b0);
    rst = 1'b0;

    // Fill three voices back-to-back
    send(1'b1, 25);
    send(1'b1, 40);
    send(1'b1, 52);
    check("t2_keys", voice_key[3*KW-1:0], {7'd52, 7'd40, 7'd25});
    check("t2_gate", voice_gate, 4'b0111);

    // All voices busy, then steal the oldest
    send(1'b1, 60);
    send(1'b1, 79);
    check("t3_v0_key", voice_key[KW-1:0], 7'd79);
    check("t3_gate", voice_gate, 4'b1111);
    check("t3_steal", steal_pulse, 1'b1);
    @(posedge clk); #1;
    check("t3_steal_drop", steal_pulse, 1'b0);

    // Note-off keeps key, freed voice reused without steal
    send(1'b0, 40);
    check("t4_gate_off", voice_gate, 4'b1101);
    check("t4_v1_key_kept", voice_key[2*KW-1:KW], 7'd40);
    send(1'b1, 66);
    check("t4_v1_key", voice_key[2*KW-1:KW], 7'd66);
    check("t4_steal", steal_pulse, 1'b0);

    // Retrigger held key, then a steal must skip the retriggered voice
    send(1'b1, 52);
    check("t5_retrig_steal", steal_pulse, 1'b0);
    send(1'b1, 90);
    check("t5_v3_key", voice_key[4*KW-1:3*KW], 7'd90);
    check("t5_v2_kept", voice_key[3*KW-1:2*KW], 7'd52);
    send(1'b0, 10);
    check("t5_off_unheld_gate", voice_gate, 4'b1111);

    // Reset mid-scan drops the latched event
    ev_valid = 1'b1;
    ev_on    = 1'b1;
    ev_key   = 7'd30;
    @(posedge clk); #1;
    ev_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    model_reset();
    check_all("t6_rst", 1'b0);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      check("t6_post_keys",  voice_key,  '0);
      check("t6_post_gate",  voice_gate, '0);
      check("t6_post_ready", ev_ready,   1'b1);
    end

    // Random events from a small key pool so matches and steals are frequent
    for (int e = 0; e < 80; e++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
      end
      send(($urandom_range(0, 9) < 6), pool[$urandom_range(0, 7)]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
